// File: rtl/repl_pkg.sv
// Shared types and width helpers for the way allocator.
// Provides the FSM state enum plus set/way index width functions.
package repl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        COMMIT
    } alloc_state_t;

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int set_w(input int sets);
        return (sets > 1) ? $clog2(sets) : 1;
    endfunction

endpackage

// File: rtl/repl_way_alloc_if.sv
// Lookup, policy, refill and invalidate bundle of the way allocator.
// slave: allocator view; master: tag-compare / fill-engine / policy view.
interface repl_way_alloc_if #(
    parameter int SET_ASSOC = 4,
    parameter int SET_NUM   = 64
);
    import repl_pkg::*;

    localparam int IW = set_w(SET_NUM);
    localparam int WW = way_w(SET_ASSOC);

    logic                 req_valid;
    logic                 req_ready;
    logic [IW-1:0]        req_index;
    logic [SET_ASSOC-1:0] hit_way;
    logic [WW-1:0]        repl_index;
    logic [SET_ASSOC-1:0] access;
    logic                 update;
    logic                 refill_valid;
    logic [IW-1:0]        refill_index;
    logic [WW-1:0]        refill_way;
    logic                 refill_done;
    logic                 inval_valid;
    logic [IW-1:0]        inval_index;
    logic [WW-1:0]        inval_way;

    modport slave (
        input  req_valid, req_index, hit_way, repl_index,
        input  refill_done, inval_valid, inval_index, inval_way,
        output req_ready, access, update,
        output refill_valid, refill_index, refill_way
    );

    modport master (
        output req_valid, req_index, hit_way, repl_index,
        output refill_done, inval_valid, inval_index, inval_way,
        input  req_ready, access, update,
        input  refill_valid, refill_index, refill_way
    );

endinterface

// File: rtl/repl_first_zero.sv
// Lowest-zero-bit priority encoder: idx = lowest clear bit of bits.
// Ports: bits (in), idx (out), found (out, 0 when every bit is set).
module repl_first_zero
    import repl_pkg::*;
#(
    parameter int WAYS = 4
) (
    input  logic [WAYS-1:0]        bits,
    output logic [way_w(WAYS)-1:0] idx,
    output logic                   found
);

    localparam int W = way_w(WAYS);

    // Scan high to low so the lowest clear bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!bits[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/repl_way_alloc.sv
// Way allocator: hit/miss -> policy access/update strobes, victim
// selection and a victim-stable refill handshake with the fill engine.
// Ports: clk, rst (sync, active-high), bus (repl_way_alloc_if.slave).
// Macro REPL_INVALID_FIRST_EN: keep per-set valid bits and prefer the
// lowest invalid way; otherwise the victim is always repl_index.
module repl_way_alloc #(
    parameter int SET_ASSOC = 4,
    parameter int SET_NUM   = 64
) (
    input logic              clk,
    input logic              rst,
    repl_way_alloc_if.slave  bus
);
    import repl_pkg::*;

    localparam int IW = set_w(SET_NUM);
    localparam int WW = way_w(SET_ASSOC);

    alloc_state_t         state;
    alloc_state_t         state_n;
    logic [SET_ASSOC-1:0] access_n;
    logic                 update_n;
    logic                 refill_valid_n;
    logic [IW-1:0]        refill_index_n;
    logic [WW-1:0]        refill_way_n;
    logic                 ready_n;
    logic [WW-1:0]        victim;
    logic [SET_ASSOC-1:0] hit_low;
    logic                 accept;

    assign accept  = bus.req_valid & bus.req_ready;
    // Isolate the lowest set bit of a possibly multi-hot hit vector.
    assign hit_low = bus.hit_way & (~bus.hit_way + SET_ASSOC'(1));

`ifdef REPL_INVALID_FIRST_EN
    logic [SET_ASSOC-1:0] valid [SET_NUM];
    logic [WW-1:0]        free_way;
    logic                 free_found;

    repl_first_zero #(
        .WAYS (SET_ASSOC)
    ) u_first_zero (
        .bits  (valid[bus.req_index]),
        .idx   (free_way),
        .found (free_found)
    );

    assign victim = free_found ? free_way : bus.repl_index;

    // The refill write comes last so it wins a same-line collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SET_NUM; s++) begin
                valid[s] <= '0;
            end
        end else begin
            if (bus.inval_valid) begin
                valid[bus.inval_index][bus.inval_way] <= 1'b0;
            end
            if (state == REFILL && bus.refill_done) begin
                valid[bus.refill_index][bus.refill_way] <= 1'b1;
            end
        end
    end
`else
    logic unused_inval;

    assign unused_inval = ^{bus.inval_valid, bus.inval_index, bus.inval_way};
    assign victim       = bus.repl_index;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            bus.access       <= '0;
            bus.update       <= 1'b0;
            bus.refill_valid <= 1'b0;
            bus.refill_index <= '0;
            bus.refill_way   <= '0;
            bus.req_ready    <= 1'b1;
        end else begin
            state            <= state_n;
            bus.access       <= access_n;
            bus.update       <= update_n;
            bus.refill_valid <= refill_valid_n;
            bus.refill_index <= refill_index_n;
            bus.refill_way   <= refill_way_n;
            bus.req_ready    <= ready_n;
        end
    end

    // Refill index/way are only loaded on an accepted miss, which keeps
    // the victim frozen for the whole refill.
    always_comb begin
        state_n        = state;
        access_n       = '0;
        update_n       = 1'b0;
        refill_valid_n = bus.refill_valid;
        refill_index_n = bus.refill_index;
        refill_way_n   = bus.refill_way;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (|bus.hit_way) begin
                        access_n = hit_low;
                        update_n = 1'b1;
                    end else begin
                        state_n        = REFILL;
                        refill_valid_n = 1'b1;
                        refill_index_n = bus.req_index;
                        refill_way_n   = victim;
                    end
                end
            end
            REFILL: begin
                if (bus.refill_done) begin
                    state_n        = COMMIT;
                    refill_valid_n = 1'b0;
                    access_n       = SET_ASSOC'(1) << bus.refill_way;
                    update_n       = 1'b1;
                end
            end
            COMMIT: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        ready_n = (state_n == IDLE);
    end

endmodule
